// File: rtl/spi_master_if.sv
// Byte-stream user handshake plus SPI pins for spi_master.
// The master modport is the block's own view; slave is the surrounding logic's view.
interface spi_master_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  tx_valid, tx_data, tx_last, miso,
        output tx_ready, rx_valid, rx_data, busy, sclk, cs, mosi
    );

    modport slave (
        output tx_valid, tx_data, tx_last, miso,
        input  tx_ready, rx_valid, rx_data, busy, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// Mode-3 SPI initiator: 8-bit MSB-first bytes, cs held low across a multi-byte
// transaction, byte-stream valid/ready on the user side, every output registered.
module spi_master #(
    parameter int HALF_DIV = 3,
    parameter int CS_SETUP = 3,
    parameter int CS_HOLD  = 3
) (
    input  logic         clk50m,
    input  logic         rst_n,
    spi_master_if.master bus
);
    localparam logic [15:0] HALF_END  = 16'(HALF_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_tx_sh;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_rx_data;
    logic        r_last;
    logic        r_tx_ready;
    logic        r_rx_valid;
    logic        r_busy;
    logic        r_sclk;
    logic        r_cs;
    logic        r_mosi;
    logic        w_accept;

    assign w_accept     = bus.tx_valid & r_tx_ready;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.busy     = r_busy;
    assign bus.sclk     = r_sclk;
    assign bus.cs       = r_cs;
    assign bus.mosi     = r_mosi;

    // Transaction sequencer: every pin and handshake output is set on the state-change edge.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_bit      <= 3'd0;
            r_tx_sh    <= 8'd0;
            r_rx_sh    <= 8'd0;
            r_rx_data  <= 8'd0;
            r_last     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b1;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_sh    <= bus.tx_data;
                        r_last     <= bus.tx_last;
                        r_cs       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= 16'd0;
                        r_bit      <= 3'd0;
                        r_state    <= S_SETUP;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_END) begin
                        r_cnt   <= 16'd0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_tx_sh[7];
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_LOW: begin
                    // miso is sampled on the same edge that raises sclk; the responder
                    // changed it a full half period earlier, so no synchronizer is needed.
                    if (r_cnt == HALF_END) begin
                        r_cnt   <= 16'd0;
                        r_sclk  <= 1'b1;
                        r_rx_sh <= {r_rx_sh[6:0], bus.miso};
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == HALF_END) begin
                        r_cnt <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_bit      <= 3'd0;
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_rx_sh;
                            if (r_last) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_tx_ready <= 1'b1;
                                r_state    <= S_WAIT;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_sclk  <= 1'b0;
                            r_mosi  <= r_tx_sh[6];
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    // Continuing a transaction skips cs setup: the next falling edge is the accept edge.
                    if (w_accept) begin
                        r_tx_sh    <= bus.tx_data;
                        r_last     <= bus.tx_last;
                        r_tx_ready <= 1'b0;
                        r_sclk     <= 1'b0;
                        r_mosi     <= bus.tx_data[7];
                        r_cnt      <= 16'd0;
                        r_state    <= S_LOW;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_END) begin
                        r_cnt   <= 16'd0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == HOLD_END) begin
                        r_cnt      <= 16'd0;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= 16'd0;
                    r_bit      <= 3'd0;
                    r_tx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_sclk     <= 1'b1;
                    r_cs       <= 1'b1;
                    r_mosi     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator for the FPGA side: drives `sclk`, `cs` and `mosi` toward an external SPI responder and captures `miso`. Uses the same framing as our SPI slave: mode 3 (sclk idles high, MOSI changes on the falling edge, both ends sample on the rising edge), 8-bit MSB-first bytes, and multi-byte transactions with `cs` held low throughout. The user side is a byte-stream valid/ready handshake plus a one-cycle received-byte strobe.

## Interface
- `HALF_DIV`, 3: sclk half-period in `clk50m` cycles (≥1). The default gives 8.33 MHz.
- `CS_SETUP`, 3: cycles from `cs` falling to the first sclk falling edge (≥1).
- `CS_HOLD`, 3: cycles from the last rising-edge phase end to `cs` rising, and also the minimum `cs` high time before the next accept (≥1).
- `clk50m`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  byte to send is present.
- `tx_data`  in  8  byte to send, MSB first.
- `tx_last`  in  1  with `tx_valid`: this byte ends the transaction.
- `tx_ready`  out  1  block accepts `tx_data` when this is high with `tx_valid`.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` holds the byte received from `miso`.
- `rx_data`  out  8  last received byte; held until the next strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `sclk`  out  1  SPI clock, idles high.
- `cs`  out  1  chip select, active low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.

## Operation
- **Outputs:** all are registered.
- **Reset values:** `cs`=1, `sclk`=1, `mosi`=0, `tx_ready`=0 during reset and 1 after, `rx_valid`=0, `rx_data`=0, `busy`=0.
- **IDLE:** `tx_ready`=1.
  - Accept (`tx_valid & tx_ready`): latch `tx_data` into the shift register, latch `tx_last`, drive `cs`←0, go to SETUP.
- **SETUP:** counts `CS_SETUP` cycles with `sclk`=1, then goes to LOW.
- **LOW:**
  - On entry: `sclk`←0 and `mosi`←current MSB of the shift register.
  - Held for `HALF_DIV` cycles, then goes to HIGH.
- **HIGH:**
  - On entry: `sclk`←1. `miso` is sampled at this same edge and shifted into the receive register LSB-side.
  - Held for `HALF_DIV` cycles.
  - If fewer than 8 bits are done, go to LOW with the next bit.
  - After the 8th bit: `rx_valid`←1 for one cycle and `rx_data`←received byte.
    - If the latched last flag is set, go to HOLD.
    - Otherwise go to WAIT.
- **WAIT (byte boundary):**
  - `cs`=0, `sclk`=1, `mosi` holds the last bit, `tx_ready`=1.
  - On accept, load the new byte and last flag and go directly to LOW; no CS_SETUP is repeated.
  - Stalls indefinitely if `tx_valid`=0.
- **HOLD:** `CS_HOLD` cycles, then `cs`←1 and `mosi`←0, go to GAP.
- **GAP:** `CS_HOLD` cycles with `tx_ready`=0, then go to IDLE.
- **`tx_ready` scope:** high only in IDLE and WAIT. `tx_valid` is ignored in all other states, and `tx_data` is never sampled outside an accept.
- **Bit counter:** 3 bits; wraps 7→0 only at the byte boundary.
- **Async reset mid-transfer:** outputs immediately return to reset values (`cs` rises, aborting the responder), the partial RX byte is discarded, and no `rx_valid` is issued.

## Timing
- All timing is relative to accept edge E0 (IDLE accept).
- `cs` goes low at E0.
- Bit k (k=0..7, k=0 is the MSB):
  - sclk falls at E0+CS_SETUP+2·HALF_DIV·k.
  - sclk rises, and `miso` is sampled, at E0+CS_SETUP+HALF_DIV·(2k+1).
- `rx_valid` is set at E0+CS_SETUP+16·HALF_DIV, lasting one cycle; WAIT or HOLD is entered on the same edge.
- **WAIT accept at edge W:** next sclk falling at W. The minimum sclk-high between bytes is HALF_DIV+1 cycles, giving a back-to-back byte period of 16·HALF_DIV+1 cycles.
- **HOLD entry at edge H:**
  - `cs` rises at H+CS_HOLD.
  - `tx_ready` rises at H+2·CS_HOLD.
- **Defaults, single byte:** cs low at E0, first fall E0+3, `rx_valid` E0+51, cs high E0+54, `tx_ready` E0+57.
- **`miso` sampling:** `miso` is not synchronized. It is valid because the responder updates it on the falling edge, ≥HALF_DIV cycles before the sample.

## Test plan
- **Single byte:** defaults, accept 0xB5 with `tx_last`=1, responder model returns 0x3C. Required:
  - bench sees MOSI 1,0,1,1,0,1,0,1 on sclk rising edges;
  - exactly 8 falling edges;
  - `rx_valid` single pulse at E0+51 with `rx_data`=0x3C;
  - `cs` low from E0 to E0+54;
  - `tx_ready` high again at E0+57.
- **Back-to-back:** 0xB5 (last=0) then 0x10 (last=1), `tx_valid` held high. Required:
  - 16 contiguous falling edges with `cs` low throughout;
  - sclk high exactly 4 cycles at the byte boundary;
  - two `rx_valid` pulses 49 cycles apart;
  - responder receives 0xB5, 0x10.
- **Stall:** 0xA5 (last=0), then `tx_valid` withheld for 50 cycles, then 0x5A (last=1). Required:
  - `sclk`=1, `cs`=0, `tx_ready`=1 held for all 50 cycles;
  - no extra edges;
  - transfer completes correctly.
- **Busy ignore:** pulse `tx_valid` with 0xFF during SHIFT of 0x00. Required: `tx_ready`=0, 0xFF never transmitted, only 0x00 appears on MOSI.
- **Reset mid-byte:** assert `rst_n`=0 asynchronously after the 3rd rising edge. Required:
  - `cs`=1, `sclk`=1, `mosi`=0 within the same cycle;
  - no `rx_valid`;
  - a fresh 0xC3 after release transfers correctly.
- **Minimum divider:** HALF_DIV=1, CS_SETUP=1, CS_HOLD=1, byte 0x81 with `miso` tied to 1. Required: sclk period 2 cycles, `rx_data`=0xFF at E0+17, `cs` high at E0+18.
